pmem_arbiter: RTL and testbench

Two-port arbiter sharing the single physical-memory line port between the L1 instruction cache and the L1 data cache. Each cache controller drives its own pmem read/write/address/wdata and waits for resp. The arbiter grants one requester at a time with round-robin tie-breaking, registers the winner's request, and forwards it downstream. It routes the downstream response back to the winner only and inserts one idle cycle between transactions.

---
 rtl/pmem_arbiter.sv | 98 +++++++++
 tb/tb_pmem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Two-port physical-memory arbiter between the L1 I-cache and D-cache.
// Round-robin on ties, latched request forwarding, one idle cycle between transactions.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t              state, state_nxt;
    logic                grant, last_grant;
    logic                lat_read, lat_write;
    logic [ADDR_W-1:0]   lat_address;
    logic [LINE_W-1:0]   lat_wdata;

    logic                i_act, d_act;
    logic                take, pick;

    assign i_act = i_pmem_read | i_pmem_write;
    assign d_act = d_pmem_read | d_pmem_write;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick      = grant;
        case (state)
            IDLE: begin
                if (i_act | d_act) begin
                    take      = 1'b1;
                    state_nxt = BUSY;
                    // On a tie the port that was not served last wins.
                    pick      = (i_act & d_act) ? ~last_grant : d_act;
                end
            end
            BUSY:    if (mem_resp) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b0;
            lat_read    <= 1'b0;
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                grant       <= pick;
                last_grant  <= pick;
                lat_read    <= pick ? d_pmem_read    : i_pmem_read;
                lat_write   <= pick ? d_pmem_write   : i_pmem_write;
                lat_address <= pick ? d_pmem_address : i_pmem_address;
                lat_wdata   <= pick ? d_pmem_wdata   : i_pmem_wdata;
            end
        end
    end

    // Strobes only in BUSY so RELEASE always shows a deasserted cycle downstream.
    assign mem_read    = (state == BUSY) & lat_read;
    assign mem_write   = (state == BUSY) & lat_write;
    assign mem_address = lat_address;
    assign mem_wdata   = lat_wdata;

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;
    assign i_pmem_resp  = mem_resp & (state == BUSY) & ~grant & ~rst;
    assign d_pmem_resp  = mem_resp & (state == BUSY) &  grant & ~rst;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: latency, tie-break, fairness, latch hold, spurious resp, reset abort.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [AW-1:0] i_pmem_address, d_pmem_address;
    logic [LW-1:0] i_pmem_wdata, d_pmem_wdata;
    logic [LW-1:0] i_pmem_rdata, d_pmem_rdata;
    logic          i_pmem_resp, d_pmem_resp;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata, mem_rdata;
    logic          mem_resp;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        step();
        mem_resp = 1'b0;
    endtask

    // Caller has the request visible in IDLE (cycle 0); resp is driven at cycle k.
    task automatic run_txn(input string tag, input bit port, input bit rd, input bit wr,
                           input logic [AW-1:0] addr, input logic [LW-1:0] wd, input int k,
                           input bit clr, input bit poke, input bit spur);
        logic [LW-1:0] rline;
        for (int c = 1; c <= k; c++) begin
            step();
            mem_resp  = (c == k);
            rline     = {8{$urandom}};
            mem_rdata = rline;
            if (poke && c == 2) begin
                i_pmem_address = i_pmem_address + 32'h40;
                d_pmem_address = d_pmem_address + 32'h40;
            end
            smp();
            chk({tag, "_rd"},    mem_read,    rd);
            chk({tag, "_wr"},    mem_write,   wr);
            chk({tag, "_addr"},  mem_address, addr);
            chk({tag, "_wdata"}, mem_wdata,   wd);
            if (c == k) begin
                chk({tag, "_iresp"}, i_pmem_resp, port == 1'b0);
                chk({tag, "_dresp"}, d_pmem_resp, port == 1'b1);
                chk({tag, "_rdata"}, port ? d_pmem_rdata : i_pmem_rdata, rline);
            end else begin
                chk({tag, "_iresp_early"}, i_pmem_resp, 1'b0);
                chk({tag, "_dresp_early"}, d_pmem_resp, 1'b0);
            end
        end
        step();
        mem_resp = spur;
        if (clr) begin
            if (port) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
            else      begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
        end
        smp();
        chk({tag, "_rel_rd"},    mem_read,    1'b0);
        chk({tag, "_rel_wr"},    mem_write,   1'b0);
        chk({tag, "_rel_iresp"}, i_pmem_resp, 1'b0);
        chk({tag, "_rel_dresp"}, d_pmem_resp, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b1;
        step(); step(); step();
        smp();
        chk("rst_rd",    mem_read,    1'b0);
        chk("rst_wr",    mem_write,   1'b0);
        chk("rst_addr",  mem_address, '0);
        chk("rst_wdata", mem_wdata,   '0);
        chk("rst_iresp", i_pmem_resp, 1'b0);
        chk("rst_dresp", d_pmem_resp, 1'b0);

        // single I read, resp at cycle 4
        step();
        rst = 1'b0; mem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
        run_txn("i_rd", 1'b0, 1'b1, 1'b0, 32'h0000_1040, '0, 4, 1'b1, 1'b0, 1'b0);

        // tie right after reset goes to D, then I after RELEASE
        next_cycle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h100; i_pmem_wdata = '0;
        d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = LINE_A5;
        run_txn("tie_d", 1'b1, 1'b0, 1'b1, 32'h200, LINE_A5, 3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        run_txn("tie_i", 1'b0, 1'b1, 1'b0, 32'h100, '0, 2, 1'b1, 1'b0, 1'b0);

        // continuous requests from both: D,I,D,I,D,I
        next_cycle();
        i_pmem_read = 1'b1; i_pmem_address = 32'h400; i_pmem_wdata = '0;
        d_pmem_read = 1'b1; d_pmem_address = 32'h800; d_pmem_wdata = '0;
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0)
                run_txn("fair_d", 1'b1, 1'b1, 1'b0, 32'h800, '0, 1 + t % 3, 1'b0, 1'b0, 1'b0);
            else
                run_txn("fair_i", 1'b0, 1'b1, 1'b0, 32'h400, '0, 1 + t % 3, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        smp();
        chk("fair_idle_rd", mem_read, 1'b0);

        // D address changes mid-BUSY; downstream address must hold
        next_cycle();
        d_pmem_read = 1'b1; d_pmem_address = 32'h300; d_pmem_wdata = '0;
        run_txn("hold", 1'b1, 1'b1, 1'b0, 32'h300, '0, 3, 1'b1, 1'b0 | 1'b1, 1'b0);

        // spurious mem_resp in IDLE and in RELEASE
        next_cycle();
        mem_resp = 1'b1;
        smp();
        chk("spur_idle_iresp", i_pmem_resp, 1'b0);
        chk("spur_idle_dresp", d_pmem_resp, 1'b0);
        chk("spur_idle_rd",    mem_read,    1'b0);
        next_cycle();
        i_pmem_read = 1'b1; i_pmem_address = 32'h600;
        run_txn("spur_i", 1'b0, 1'b1, 1'b0, 32'h600, '0, 2, 1'b1, 1'b0, 1'b1);
        next_cycle();
        d_pmem_write = 1'b1; d_pmem_address = 32'h700; d_pmem_wdata = LINE_A5;
        run_txn("spur_d", 1'b1, 1'b0, 1'b1, 32'h700, LINE_A5, 1, 1'b1, 1'b0, 1'b0);

        // reset in the 2nd BUSY cycle of an I read
        next_cycle();
        i_pmem_read = 1'b1; i_pmem_address = 32'h500;
        step();
        smp();
        chk("abort_busy_rd", mem_read, 1'b1);
        step();
        rst = 1'b1; mem_resp = 1'b1;
        smp();
        chk("abort_rst_iresp", i_pmem_resp, 1'b0);
        chk("abort_rst_dresp", d_pmem_resp, 1'b0);
        step();
        rst = 1'b0; mem_resp = 1'b0;
        d_pmem_read = 1'b1; d_pmem_address = 32'h900; d_pmem_wdata = '0;
        smp();
        chk("abort_next_rd",   mem_read,    1'b0);
        chk("abort_next_addr", mem_address, '0);
        chk("abort_next_iresp", i_pmem_resp, 1'b0);
        run_txn("abort_tie_d", 1'b1, 1'b1, 1'b0, 32'h900, '0, 2, 1'b1, 1'b0, 1'b0);
        next_cycle();
        run_txn("abort_tie_i", 1'b0, 1'b1, 1'b0, 32'h500, '0, 1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
